// File: rtl/plic_lite_if.sv
// D-bus register access channel for plic_lite: a single-beat request held
// until a one-cycle ack, with read data valid only in the ack cycle.
interface plic_lite_if;
  logic        req;
  logic        we;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/plic_lite.sv
// Lightweight platform interrupt controller: level gateways, per-source priority
// and enable, threshold, claim/complete, and one registered external irq output.
module plic_lite #(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] src,
  plic_lite_if.slave      bus,
  output logic            irq_ext
);

  // Handshake: an access starts on any req cycle that is not itself an ack
  // cycle; all side effects and the read sample happen on that cycle's edge,
  // and ack/rdata are presented for exactly the following cycle.
  logic [PRIO_W-1:0] prio_q [1:NSRC];
  logic [PRIO_W-1:0] prio_d [1:NSRC];
  logic [NSRC:1]     en_q, en_d, pend_q, pend_d, insv_q, insv_d;
  logic [PRIO_W-1:0] thr_q, thr_d;
  logic              ack_q, ack_d, irq_q, irq_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [PRIO_W-1:0] best_prio;
  logic [4:0]        cand;
  logic [31:0]       rmux;
  logic              acc, rd, wr;
  logic              is_prio, is_pend, is_en, is_thr, is_claim;
  logic [21:0]       word;
  logic [9:0]        prio_idx;
  logic              unused_bits;

  assign unused_bits = ^{bus.addr[1:0], bus.wdata};

  assign word     = bus.addr[23:2];
  assign prio_idx = bus.addr[11:2];
  assign acc      = bus.req & ~ack_q;
  assign rd       = acc & ~bus.we;
  assign wr       = acc & bus.we;

  assign is_prio  = (bus.addr[23:12] == 12'h000) && (prio_idx >= 10'd1) &&
                    (prio_idx <= 10'(NSRC));
  assign is_pend  = (word == 22'h000400);
  assign is_en    = (word == 22'h000800);
  assign is_thr   = (word == 22'h080000);
  assign is_claim = (word == 22'h080001);

  // Ascending scan with a strict compare keeps the lowest ID on priority ties;
  // seeding with the threshold makes priority 0 unable to qualify.
  always_comb begin
    best_prio = thr_q;
    cand      = '0;
    for (int i = 1; i <= NSRC; i++) begin
      if (pend_q[i] && en_q[i] && (prio_q[i] > best_prio)) begin
        best_prio = prio_q[i];
        cand      = 5'(i);
      end
    end
  end

  always_comb begin
    rmux = '0;
    if (is_prio) begin
      for (int i = 1; i <= NSRC; i++) begin
        if (prio_idx == 10'(i)) rmux = 32'(prio_q[i]);
      end
    end
    if (is_pend)  rmux = 32'({pend_q, 1'b0});
    if (is_en)    rmux = 32'({en_q, 1'b0});
    if (is_thr)   rmux = 32'(thr_q);
    if (is_claim) rmux = 32'(cand);
  end

  always_comb begin
    for (int i = 1; i <= NSRC; i++) prio_d[i] = prio_q[i];
    en_d  = en_q;
    thr_d = thr_q;
    insv_d = insv_q;
    pend_d = pend_q;
    // Gateway looks at the old in-service bit, so a complete only re-opens it next edge.
    for (int i = 1; i <= NSRC; i++) begin
      if (src[i-1] && !insv_q[i]) pend_d[i] = 1'b1;
    end
    if (rd && is_claim && (cand != 5'd0)) begin
      for (int i = 1; i <= NSRC; i++) begin
        if (cand == 5'(i)) begin
          pend_d[i] = 1'b0;
          insv_d[i] = 1'b1;
        end
      end
    end
    if (wr) begin
      if (is_prio) begin
        for (int i = 1; i <= NSRC; i++) begin
          if (prio_idx == 10'(i)) prio_d[i] = bus.wdata[PRIO_W-1:0];
        end
      end
      if (is_en)  en_d  = bus.wdata[NSRC:1];
      if (is_thr) thr_d = bus.wdata[PRIO_W-1:0];
      if (is_claim) begin
        for (int i = 1; i <= NSRC; i++) begin
          if (bus.wdata[4:0] == 5'(i)) insv_d[i] = 1'b0;
        end
      end
    end
    ack_d   = acc;
    rdata_d = rd ? rmux : 32'd0;
    irq_d   = (cand != 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= NSRC; i++) prio_q[i] <= '0;
      en_q    <= '0;
      thr_q   <= '0;
      pend_q  <= '0;
      insv_q  <= '0;
      ack_q   <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      for (int i = 1; i <= NSRC; i++) prio_q[i] <= prio_d[i];
      en_q    <= en_d;
      thr_q   <= thr_d;
      pend_q  <= pend_d;
      insv_q  <= insv_d;
      ack_q   <= ack_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign irq_ext   = irq_q;

endmodule

// File: doc/plic_lite.md
PLIC_LITE -- requirements
Module: plic_lite

Interface
REQ-001 Parameter NSRC, default 8, meaning number of interrupt sources (IDs 1..NSRC; ID 0 reserved = "no interrupt"), legal range 1..31.
REQ-002 Parameter PRIO_W, default 3, meaning priority/threshold field width in bits.
REQ-003 clk  input  1  system clock; the block has one clock, and all logic is on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 src  input  NSRC  level interrupt requests; bit i-1 drives ID i; synchronous to clk.
REQ-006 req  input  1  D-bus access request; held until ack.
REQ-007 we  input  1  1 = write, 0 = read; qualified by req.
REQ-008 addr  input  24  byte offset within the block window; bits [1:0] ignored.
REQ-009 wdata  input  32  write data.
REQ-010 rdata  output  32  read data; valid only in the ack cycle, 0 otherwise.
REQ-011 ack  output  1  one-cycle completion pulse.
REQ-012 irq_ext  output  1  external interrupt request to core0, registered.

Function
REQ-013 Register map: 0x000000+4*i priority[i] (RW, i=1..NSRC, PRIO_W LSBs); 0x001000 pending (RO, bit i = ID i, bit 0 reads 0); 0x002000 enable (RW, bit i = ID i, bit 0 hardwired 0); 0x200000 threshold (RW, PRIO_W LSBs); 0x200004 claim/complete.
REQ-014 Unmapped addresses: reads return 0, writes are ignored, and ack is still generated.
REQ-015 Handshake: ack is asserted exactly 1 cycle after the first req cycle of an access, and no ack follows in the next cycle; a req still high after ack starts a new access.
REQ-016 Exactly one register side effect is performed per ack.
REQ-017 Gateway per ID: pending[i] sets on the clk edge where src[i]=1, pending[i]=0 and inservice[i]=0.
REQ-018 pending[i] clears only by claim; deasserting src[i] does not clear it.
REQ-019 Candidate: the ID with pending & enable and priority > threshold, with the highest priority.
REQ-020 Candidate tie-break: among equal priorities, the lowest ID wins.
REQ-021 If no such ID exists, the candidate is 0.
REQ-022 Priority 0 never qualifies.
REQ-023 irq_ext = registered (candidate != 0), i.e. 1 cycle after the state change, including changes to enable, priority or threshold.
REQ-024 Claim (read of 0x200004) returns the candidate computed in the access cycle.
REQ-025 If the claimed candidate is nonzero, the claim clears pending[cand] and sets inservice[cand] at the ack edge.
REQ-026 Complete (write of 0x200004) with wdata[4:0]=ID, where 1<=ID<=NSRC: clears inservice[ID]; other values and IDs not in service are ignored.
REQ-027 Simultaneous events: a claim and a gateway set on the same ID in the same cycle results in the claim winning (pending=0, inservice=1).
REQ-028 Simultaneous events: a complete and a new src level on the same ID in the same cycle results in pending setting on the following cycle, not the same one.
REQ-029 Writes to the pending register, and write bits above PRIO_W/NSRC, have no effect; those bits read 0.

Reset
REQ-030 Asynchronous assertion of rst_n=0 immediately clears priority, enable, threshold, pending and inservice, and drives irq_ext=0, ack=0 and rdata=0, including mid-access.
REQ-031 After rst_n deasserts, the first gateway sample occurs on the first clk edge.
REQ-032 An access in flight when reset asserts is dropped with no ack.

Verification
REQ-033 Single source: priority[3]=2, enable=0x08, threshold=0, src[2]=1 -> pending=0x08, irq_ext=1; claim reads 3; pending=0; irq_ext=0 next cycle.
REQ-034 Arbitration: IDs 2 and 5 have priority 4 and ID 7 has priority 6, all pending and enabled -> claims return 7, then 2, then 5; a fourth claim reads 0.
REQ-035 Threshold: priority[1]=3, threshold=3 -> irq_ext=0; threshold write of 2 -> irq_ext=1 exactly one cycle after ack.
REQ-036 In-service masking: src[0] held high after claiming ID 1 -> no re-pend until complete writes 1; pending[1]=1 on the second edge after that ack.
REQ-037 Reset mid-operation: rst_n pulsed low during a claim with req high -> no ack, all registers read 0, irq_ext=0.
REQ-038 Bus corner case: a read from 0x300000 returns 0 with ack; back-to-back req held for 4 cycles -> ack on cycles 2 and 4 only.
